// File: rtl/flag_scheduler_if.sv
// flag_scheduler_if: decode/flags-stage signals exchanged with the flag scheduler
interface flag_scheduler_if;
  logic       IssueValid;
  logic       IssueSetsFlags;
  logic       BranchReq;
  logic [2:0] BranchCond;
  logic       Flush;
  logic       arithCarry;
  logic       logicCarry;
  logic       zero;
  logic       sign;
  logic       overflow;
  logic [1:0] CarrySelectDelayed;
  logic       Stall;
  logic       BranchResolved;
  logic       BranchTaken;
  logic       FlagsBusy;
  logic [7:0] StallCycles;
  modport master (
    output IssueValid, IssueSetsFlags, BranchReq, BranchCond, Flush,
           arithCarry, logicCarry, zero, sign, overflow, CarrySelectDelayed,
    input  Stall, BranchResolved, BranchTaken, FlagsBusy, StallCycles
  );
  modport slave (
    input  IssueValid, IssueSetsFlags, BranchReq, BranchCond, Flush,
           arithCarry, logicCarry, zero, sign, overflow, CarrySelectDelayed,
    output Stall, BranchResolved, BranchTaken, FlagsBusy, StallCycles
  );
endinterface

// File: rtl/flag_scheduler.sv
// flag_scheduler: flag-writer interlock and conditional branch resolution
module flag_scheduler #(
  parameter int PIPE_DEPTH = 3
) (
  input logic             clk,
  input logic             reset,
  flag_scheduler_if.slave bus
);
  localparam int PW = PIPE_DEPTH - 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pend;
  logic pending, carry, cond, resolve, inc, resolved_q, taken_q;
  logic [7:0] stall_cycles_q;
  assign pending            = |pend;
  assign bus.FlagsBusy      = pending;
  assign bus.Stall          = bus.BranchReq & pending & ~bus.Flush;
  assign bus.BranchResolved = resolved_q;
  assign bus.BranchTaken    = taken_q;
  assign bus.StallCycles    = stall_cycles_q;
  // carry source select and branch condition evaluation on the current flags
  always_comb begin
    carry = bus.CarrySelectDelayed[1] ? bus.CarrySelectDelayed[0] :
            (bus.CarrySelectDelayed[0] ? bus.logicCarry : bus.arithCarry);
    case (bus.BranchCond)
      3'd0:    cond = 1'b1;
      3'd1:    cond = bus.zero;
      3'd2:    cond = ~bus.zero;
      3'd3:    cond = carry;
      3'd4:    cond = ~carry;
      3'd5:    cond = bus.sign;
      3'd6:    cond = ~bus.sign;
      default: cond = bus.overflow;
    endcase
  end
  // a branch waits (and is counted) while writers are pending; it resolves once they drain
  always_comb begin
    inc       = ~bus.Flush & pending & (state == WAIT | bus.BranchReq);
    resolve   = ~bus.Flush & bus.BranchReq & ~pending;
    state_nxt = inc ? WAIT : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end
  // in-flight writer tracking, registered branch outcome and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pend           <= '0;
      resolved_q     <= 1'b0;
      taken_q        <= 1'b0;
      stall_cycles_q <= '0;
    end else if (bus.Flush) begin
      pend       <= '0;
      resolved_q <= 1'b0;
    end else begin
      pend       <= (pend >> 1) | (PW'(bus.IssueValid & bus.IssueSetsFlags & ~bus.Stall) << (PW - 1));
      resolved_q <= resolve;
      if (resolve) taken_q <= cond;
      if (inc && stall_cycles_q != 8'hFF) stall_cycles_q <= stall_cycles_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_flag_scheduler.sv
// tb_flag_scheduler: directed vector bench for flag_scheduler with PIPE_DEPTH=3
module tb_flag_scheduler;
  typedef struct {
    logic       iv, isf, br;
    logic [2:0] cond;
    logic       fl;
    logic [4:0] f;
    logic [1:0] csd;
    logic       st, bz, rs, tk;
    logic [7:0] sc;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t v[34];
  flag_scheduler_if bus();
  flag_scheduler #(.PIPE_DEPTH(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t in_v(input logic iv, isf, br, input logic [2:0] cond,
                                input logic fl, input logic [4:0] f, input logic [1:0] csd);
    vec_t x = '{iv, isf, br, cond, fl, f, csd, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    return x;
  endfunction
  task automatic drive(input vec_t x);
    bus.IssueValid = x.iv;
    bus.IssueSetsFlags = x.isf;
    bus.BranchReq = x.br;
    bus.BranchCond = x.cond;
    bus.Flush = x.fl;
    {bus.arithCarry, bus.logicCarry, bus.zero, bus.sign, bus.overflow} = x.f;
    bus.CarrySelectDelayed = x.csd;
  endtask
  task automatic chk(input string n, input int i, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", n, i, a, e);
    end
  endtask
  task automatic chk_all(input int i, input logic st, bz, rs, tk, input logic [7:0] sc);
    chk("stall", i, 8'(bus.Stall), 8'(st));
    chk("flags_busy", i, 8'(bus.FlagsBusy), 8'(bz));
    chk("resolved", i, 8'(bus.BranchResolved), 8'(rs));
    chk("taken", i, 8'(bus.BranchTaken), 8'(tk));
    chk("stall_cycles", i, bus.StallCycles, sc);
  endtask
  task automatic apply(input vec_t x, input int i);
    drive(x);
    #1;
    chk("stall", i, 8'(bus.Stall), 8'(x.st));
    chk("flags_busy", i, 8'(bus.FlagsBusy), 8'(x.bz));
    @(posedge clk);
    #1;
    chk("resolved", i, 8'(bus.BranchResolved), 8'(x.rs));
    chk("taken", i, 8'(bus.BranchTaken), 8'(x.tk));
    chk("stall_cycles", i, bus.StallCycles, x.sc);
  endtask
  initial begin
    logic [7:0] sweep;
    sweep = 8'b1011_0101;
    // fields: iv isf br cond fl {ac,lc,z,s,o} csd | stall busy resolved taken stall_cycles
    v[0]  = '{0, 0, 1, 1, 0, 5'b00100, 0, 0, 0, 1, 1, 0};
    v[1]  = '{0, 0, 1, 2, 0, 5'b00100, 0, 0, 0, 1, 0, 0};
    v[2]  = '{0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0};
    v[3]  = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0};
    v[4]  = '{0, 0, 1, 3, 0, 5'b00000, 1, 1, 1, 0, 0, 1};
    v[5]  = '{0, 0, 1, 3, 0, 5'b00000, 1, 1, 1, 0, 0, 2};
    v[6]  = '{0, 0, 1, 3, 0, 5'b01000, 1, 0, 0, 1, 1, 2};
    v[7]  = '{0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 2};
    v[8]  = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 2};
    v[9]  = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 1, 2};
    v[10] = '{0, 0, 1, 4, 0, 5'b00000, 3, 1, 1, 0, 1, 3};
    v[11] = '{0, 0, 1, 4, 0, 5'b00000, 3, 1, 1, 0, 1, 4};
    v[12] = '{0, 0, 1, 4, 0, 5'b00000, 3, 0, 0, 1, 0, 4};
    v[13] = '{0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 4};
    v[14] = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 4};
    v[15] = '{1, 1, 1, 0, 0, 5'b00000, 0, 1, 1, 0, 0, 5};
    v[16] = '{0, 0, 1, 0, 0, 5'b00000, 0, 1, 1, 0, 0, 6};
    v[17] = '{0, 0, 1, 0, 0, 5'b00000, 0, 0, 0, 1, 1, 6};
    v[18] = '{0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 6};
    v[19] = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 6};
    v[20] = '{0, 0, 1, 0, 0, 5'b00000, 0, 1, 1, 0, 1, 7};
    v[21] = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 1, 8};
    v[22] = '{1, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0, 1, 9};
    v[23] = '{0, 0, 1, 1, 1, 5'b00000, 0, 0, 1, 0, 1, 9};
    v[24] = '{0, 0, 1, 1, 0, 5'b00000, 0, 0, 0, 1, 0, 9};
    for (int i = 0; i < 8; i++)
      v[25+i] = '{0, 0, 1, 3'(i), 0, 5'b00011, 2, 0, 0, 1, sweep[i], 9};
    v[33] = '{0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 9};
    drive(in_v(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 0, 0, 0, 0, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 34; i++) apply(v[i], i);
    drive(in_v(1, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(in_v(0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("sat_enter_stall", 100, 8'(bus.Stall), 8'd1);
    @(posedge clk);
    #1;
    chk("sat_enter_count", 100, bus.StallCycles, 8'd10);
    drive(in_v(1, 1, 0, 0, 0, 0, 0));
    repeat (100) @(posedge clk);
    #1;
    chk("sat_mid_count", 101, bus.StallCycles, 8'd110);
    repeat (200) @(posedge clk);
    #1;
    chk("sat_final_count", 102, bus.StallCycles, 8'd255);
    chk("sat_busy", 102, 8'(bus.FlagsBusy), 8'd1);
    drive(in_v(0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("wait_stall", 103, 8'(bus.Stall), 8'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all(104, 0, 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    chk_all(105, 0, 0, 1, 1, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
